// File: rtl/union_reg_arbiter_if.sv
// Handshake and result bus between two write requesters and the shared union register.
interface union_reg_arbiter_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LANES = 2
);
    localparam int unsigned LANE_W  = WIDTH / LANES;
    localparam int unsigned LANE_IW = $clog2(LANES);

    logic               a_valid;
    logic               a_ready;
    logic [WIDTH-1:0]   a_data;
    logic               a_lock;
    logic               b_valid;
    logic               b_ready;
    logic [LANE_IW-1:0] b_lane;
    logic [LANE_W-1:0]  b_data;
    logic               b_lock;
    logic [WIDTH-1:0]   q_word;
    logic               upd;
    logic [1:0]         owner;

    // Requester side: drives requests, observes grants and register contents.
    modport master (
        output a_valid, a_data, a_lock, b_valid, b_lane, b_data, b_lock,
        input  a_ready, b_ready, q_word, upd, owner
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_data, a_lock, b_valid, b_lane, b_data, b_lock,
        output a_ready, b_ready, q_word, upd, owner
    );
endinterface

// File: rtl/union_reg_arbiter.sv
// Round-robin arbiter for a word writer (A) and a lane writer (B) sharing one
// packed-union register, with bounded locked bursts.
module union_reg_arbiter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LANES    = 2,
    parameter int unsigned MAX_HOLD = 3
) (
    input  logic                clk,
    input  logic                rst,
    union_reg_arbiter_if.slave  bus
);
    localparam int unsigned LANE_W  = WIDTH / LANES;
    localparam int unsigned CNT_W   = $clog2(MAX_HOLD + 1);
    localparam bit          LOCK_EN = (MAX_HOLD > 1);

    // State encoding doubles as the {OWN_B, OWN_A} owner flags.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_e;

    typedef union packed {
        logic [WIDTH-1:0]              word;
        logic [LANES-1:0][LANE_W-1:0]  lane;
    } reg_u;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             last_b_q, last_b_d;
    reg_u             reg_q, reg_d;
    logic             upd_q, upd_d;

    logic             a_ready_c;
    logic             b_ready_c;
    logic             a_xfer;
    logic             b_xfer;
    logic [CNT_W-1:0] hold_inc;
    logic             hold_last;

    // Grant: owner-only while locked, round-robin on ties while idle.
    always_comb begin
        a_ready_c = 1'b0;
        b_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                a_ready_c = bus.a_valid & (~bus.b_valid | last_b_q);
                b_ready_c = bus.b_valid & ~a_ready_c;
            end
            OWN_A:   a_ready_c = bus.a_valid;
            OWN_B:   b_ready_c = bus.b_valid;
            default: ;
        endcase
    end

    assign a_xfer    = bus.a_valid & a_ready_c;
    assign b_xfer    = bus.b_valid & b_ready_c;
    assign hold_inc  = hold_q + CNT_W'(1);
    assign hold_last = (hold_inc == CNT_W'(MAX_HOLD));

    // Next register contents, round-robin pointer and ownership state.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        last_b_d = last_b_q;
        reg_d    = reg_q;
        upd_d    = a_xfer | b_xfer;

        if (a_xfer) begin
            reg_d.word = bus.a_data;
            last_b_d   = 1'b0;
        end
        if (b_xfer) begin
            reg_d.lane[bus.b_lane] = bus.b_data;
            last_b_d               = 1'b1;
        end

        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (LOCK_EN && a_xfer && bus.a_lock) begin
                    state_d = OWN_A;
                    hold_d  = CNT_W'(1);
                end else if (LOCK_EN && b_xfer && bus.b_lock) begin
                    state_d = OWN_B;
                    hold_d  = CNT_W'(1);
                end
            end
            OWN_A: begin
                if (!bus.a_valid) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (!bus.a_lock || hold_last) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_inc;
                end
            end
            OWN_B: begin
                if (!bus.b_valid) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (!bus.b_lock || hold_last) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_inc;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // State registers; reset discards any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            last_b_q <= 1'b1;
            reg_q    <= '0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            last_b_q <= last_b_d;
            reg_q    <= reg_d;
            upd_q    <= upd_d;
        end
    end

    assign bus.a_ready = a_ready_c;
    assign bus.b_ready = b_ready_c;
    assign bus.q_word  = reg_q.word;
    assign bus.upd     = upd_q;
    assign bus.owner   = state_q;

endmodule

// File: tb/tb_union_reg_arbiter.sv
// Directed bench for union_reg_arbiter with a behavioural ownership model.
module tb_union_reg_arbiter;
    localparam int unsigned WIDTH    = 4;
    localparam int unsigned LANES    = 2;
    localparam int unsigned MAX_HOLD = 3;
    localparam int unsigned LANE_W   = WIDTH / LANES;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    union_reg_arbiter_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    union_reg_arbiter #(
        .WIDTH    (WIDTH),
        .LANES    (LANES),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: owner 0=none 1=A 2=B; last 1=A 2=B.
    bit m_on = 1'b0;
    int m_owner, m_cnt, m_last, m_q, m_upd;
    int m_g, m_lock, m_sh;
    int c_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Who the rules say gets the register this cycle.
    function automatic int m_grant();
        if (m_owner == 1) return bus.a_valid ? 1 : 0;
        if (m_owner == 2) return bus.b_valid ? 2 : 0;
        if (bus.a_valid && bus.b_valid) return (m_last == 1) ? 2 : 1;
        if (bus.a_valid) return 1;
        if (bus.b_valid) return 2;
        return 0;
    endfunction

    // Model advance at each edge.
    always @(posedge clk) begin
        if (rst) begin
            m_on = 1'b1; m_owner = 0; m_cnt = 0; m_last = 2; m_q = 0; m_upd = 0;
        end else if (m_on) begin
            m_g    = m_grant();
            m_upd  = (m_g != 0) ? 1 : 0;
            m_lock = 0;
            if (m_g == 1) begin
                m_q    = int'(bus.a_data);
                m_last = 1;
                m_lock = int'(bus.a_lock);
            end else if (m_g == 2) begin
                m_sh   = int'(bus.b_lane) * LANE_W;
                m_q    = ((m_q & ~(3 << m_sh)) | (int'(bus.b_data) << m_sh)) & 15;
                m_last = 2;
                m_lock = int'(bus.b_lock);
            end
            if (m_owner == 0) begin
                if (m_g != 0 && m_lock != 0 && MAX_HOLD > 1) begin
                    m_owner = m_g; m_cnt = 1;
                end
            end else if (m_g == 0) begin
                m_owner = 0; m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_lock == 0 || m_cnt == MAX_HOLD) begin
                    m_owner = 0; m_cnt = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_on) begin
            c_g = m_grant();
            chk("a_ready", 32'(bus.a_ready), 32'(c_g == 1));
            chk("b_ready", 32'(bus.b_ready), 32'(c_g == 2));
            chk("q_word",  32'(bus.q_word),  32'(m_q));
            chk("upd",     32'(bus.upd),     32'(m_upd));
            chk("owner",   32'(bus.owner),   32'(m_owner));
        end
    end

    // Apply one cycle of inputs, return at the following negedge.
    task automatic step(input logic r, input logic av, input logic [3:0] ad, input logic al,
                        input logic bv, input logic bl, input logic [1:0] bd, input logic bk);
        @(posedge clk);
        #1;
        rst = r;
        bus.a_valid = av; bus.a_data = ad; bus.a_lock = al;
        bus.b_valid = bv; bus.b_lane = bl; bus.b_data = bd; bus.b_lock = bk;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.a_valid = 1'b0; bus.a_data = '0; bus.a_lock = 1'b0;
        bus.b_valid = 1'b0; bus.b_lane = '0; bus.b_data = '0; bus.b_lock = 1'b0;

        // Reset with random inputs.
        repeat (2) step(1'b1, 1'($urandom), 4'($urandom), 1'($urandom),
                        1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
        chk("rst_q_word", 32'(bus.q_word), 32'h0);
        chk("rst_upd",    32'(bus.upd),    32'h0);
        chk("rst_owner",  32'(bus.owner),  32'h0);

        // First tie after reset goes to A.
        step(1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        chk("first_tie_a", 32'(bus.a_ready), 32'h1);
        chk("first_tie_b", 32'(bus.b_ready), 32'h0);

        // A alone.
        step(1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("a_alone_ready", 32'(bus.a_ready), 32'h1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("a_alone_q",   32'(bus.q_word), 32'hA);
        chk("a_alone_upd", 32'(bus.upd),    32'h1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("upd_drop", 32'(bus.upd), 32'h0);

        // B lane writes.
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
        chk("b_lane1_ready", 32'(bus.b_ready), 32'h1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
        chk("b_lane1_q", 32'(bus.q_word), 32'h6);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("b_lane0_q", 32'(bus.q_word), 32'h7);

        // Alternating grants without lock.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 4'(i), 1'b0, 1'b1, 1'(i), 2'(i), 1'b0);
            chk("rr_a",     32'(bus.a_ready), 32'((i % 2) == 0));
            chk("rr_b",     32'(bus.b_ready), 32'((i % 2) == 1));
            chk("rr_owner", 32'(bus.owner),   32'h0);
        end

        // Burst cap: A, A, A then B.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4'(8 + i), 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
            chk("cap_a",     32'(bus.a_ready), 32'(i < 3));
            chk("cap_b",     32'(bus.b_ready), 32'(i == 3));
            chk("cap_owner", 32'(bus.owner),   32'((i == 1 || i == 2) ? 1 : 0));
        end

        // Early release by dropping valid.
        step(1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1);
        chk("er_a0", 32'(bus.a_ready), 32'h1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1);
        chk("er_owner1", 32'(bus.owner),   32'h1);
        chk("er_b1",     32'(bus.b_ready), 32'h0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1);
        chk("er_owner2", 32'(bus.owner),   32'h0);
        chk("er_b2",     32'(bus.b_ready), 32'h1);

        // Reset while B owns; in-flight transfer discarded.
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1);
        chk("mid_owner_b", 32'(bus.owner), 32'h2);
        step(1'b0, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
        chk("mid_rst_owner", 32'(bus.owner),   32'h0);
        chk("mid_rst_q",     32'(bus.q_word),  32'h0);
        chk("mid_rst_upd",   32'(bus.upd),     32'h0);
        chk("mid_rst_tie_a", 32'(bus.a_ready), 32'h1);
        chk("mid_rst_tie_b", 32'(bus.b_ready), 32'h0);

        repeat (3) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/union_reg_arbiter.md
Name: union_reg_arbiter

Overview:
- Arbitrates two requesters sharing one packed-union register: a `WIDTH`-bit word view and a `LANES` x `LANE_W` lane view over the same bits.
- Requester A writes the whole word; requester B writes one lane.
- Round-robin arbitration. A granted requester holding `lock` may own the register for a bounded burst.
- Sits beside the datapath modules that read the union in either view.

Parameters:
- WIDTH, 4, total register width (word view)
- LANES, 2, number of lanes in lane view; power of two, >=2, divides `WIDTH`
- LANE_W, WIDTH/LANES, lane width (derived, do not override)
- MAX_HOLD, 3, max transfers per locked ownership; >=1

Ports:
- clk  in  1  clock
- rst  in  1  reset
- a_valid  in  1  A write request
- a_ready  out  1  A grant; transfer when `a_valid` & `a_ready`
- a_data  in  WIDTH  A word value
- a_lock  in  1  A requests to keep ownership after this transfer
- b_valid  in  1  B write request
- b_ready  out  1  B grant
- b_lane  in  $clog2(LANES)  B lane index
- b_data  in  LANE_W  B lane value
- b_lock  in  1  B requests to keep ownership
- q_word  out  WIDTH  register contents (lane i = bits [i*LANE_W +: LANE_W])
- upd  out  1  registered pulse: register was written on the previous edge
- owner  out  2  {OWN_B, OWN_A} state flags

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - `q_word` = 0, `upd` = 0, `owner` = 0.
  - State IDLE, hold count 0, last-granted = B, so A wins the first tie.
- Ready timing: `a_ready`/`b_ready` are combinational from state, the valids and last-granted. They are never both 1 in one cycle.
- IDLE grants:
  - Only one valid → grant it.
  - Both valid → grant the requester that is not last-granted.
  - None valid → no grant.
- Write effect (applied at the next edge; `q_word` and `upd`=1 visible the cycle after the transfer):
  - A transfer: register <= `a_data`.
  - B transfer: lane[`b_lane`] <= `b_data`; other lanes unchanged.
- Last-granted: updated on every transfer.
- FSM states: IDLE, OWN_A, OWN_B.
  - IDLE → OWN_X when X transfers with X_lock=1 and MAX_HOLD>1. Hold count := 1.
  - OWN_X: only X may be ready, and only when X_valid; the other requester's ready = 0.
    - Each X transfer increments the hold count.
  - OWN_X → IDLE on any of:
    - X transfers with X_lock=0;
    - the transfer brings the count to MAX_HOLD (forced release; that transfer still completes);
    - X_valid=0 (release; nothing granted that cycle).
  - On entering IDLE, hold count := 0.
- MAX_HOLD=1: lock is ignored; the FSM never leaves IDLE.
- Simultaneous valids in OWN_X: the other requester waits. Its request is served in the IDLE cycle after release, via round-robin.
- Valid/data stability: valid may drop without a transfer. No requirement on data stability while waiting.
- Reset mid-burst: all state returns to reset values on that edge; an in-flight transfer in the reset cycle is discarded.
- `upd` is high for exactly one cycle per transfer; back-to-back transfers give continuous `upd`.

Test Plan (WIDTH=4, LANES=2, MAX_HOLD=3):
1. Hold `rst`=1 for 2 cycles with random inputs → `q_word`=0, `upd`=0, `owner`=0; after release, `a_valid`=`b_valid`=1 gives `a_ready`=1, `b_ready`=0.
2. A alone: `a_data`=4'hA, `a_lock`=0 → `a_ready`=1 same cycle; next cycle `q_word`=4'hA, `upd`=1; following cycle `upd`=0.
3. Then B alone: `b_lane`=1, `b_data`=2'b01 → next cycle `q_word`=4'h6; then `b_lane`=0, `b_data`=2'b11 → `q_word`=4'h7.
4. Both valid, no lock, 6 cycles → grant order A, B, A, B, A, B; `owner` stays 0.
5. Burst cap, `a_lock`=1 and both valid:
   - grants A (IDLE), A (OWN_A, count 2), A (count 3, release);
   - next cycle IDLE grants B;
   - `owner` = 01 for the two middle cycles only.
6. Early release and reset:
   - A locks at count 1, then drops `a_valid` → next cycle IDLE, B granted.
   - Separately, assert `rst` mid-OWN_B → state IDLE, `q_word`=0, next tie grants A.
